// File: rtl/ahb_rr_burst_arbiter_pkg.sv
// Shared arbiter types and helpers: FSM state encoding, default watchdog limit,
// and one-hot to binary index conversion.
package AHB_package;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int AHB_ARB_TIMEOUT = 16;
  localparam int AHB_MAX_MASTERS = 32;

  // OR-reduction of set bit positions; exact for a one-hot (or zero) input.
  function automatic int unsigned onehot_to_idx(input logic [AHB_MAX_MASTERS-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < AHB_MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_rr_burst_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning from start,
// wrapping modulo MASTER_NUM. Zero latency, no state.
module rr_pick
  import AHB_package::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int MASTER_BIT = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [MASTER_BIT-1:0] start,
  output logic [MASTER_NUM-1:0] onehot,
  output logic [MASTER_BIT-1:0] index,
  output logic                  valid
);

  logic                       found;
  logic [MASTER_BIT-1:0]      pos;
  logic [AHB_MAX_MASTERS-1:0] oh_ext;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    pos    = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      pos = MASTER_BIT'((int'(start) + i) % MASTER_NUM);
      if (!found && req[pos]) begin
        onehot[pos] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    oh_ext                 = '0;
    oh_ext[MASTER_NUM-1:0] = onehot;
  end

  assign index = MASTER_BIT'(onehot_to_idx(oh_ext));
  assign valid = |req;

endmodule

// File: rtl/ahb_rr_burst_arbiter.sv
// Per-slave round-robin AHB arbiter holding ownership through the accepted last beat.
// Optional stall watchdog enabled by defining AHB_ARB_TIMEOUT_EN.
module ahb_rr_burst_arbiter
  import AHB_package::*;
#(
  parameter int MASTER_NUM     = 4,
  parameter int MASTER_BIT     = $clog2(MASTER_NUM),
  parameter int TIMEOUT_CYCLES = AHB_ARB_TIMEOUT,
  parameter int TO_BIT         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [MASTER_NUM-1:0] hreq,
  input  logic [MASTER_NUM-1:0] hlast,
  input  logic                  hwait,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic                  hsel,
  output logic [MASTER_BIT-1:0] hmaster,
  output logic                  timeout_err
);

  arb_state_e            state_q, state_d;
  logic [MASTER_BIT-1:0] owner_q, owner_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [MASTER_BIT-1:0] rr_ptr_q, rr_ptr_d;

  logic                  rel_normal;
  logic                  to_hit;
  logic                  release_any;
  logic [MASTER_BIT-1:0] owner_inc;
  logic [MASTER_BIT-1:0] pick_start;
  logic [MASTER_NUM-1:0] pick_onehot;
  logic [MASTER_BIT-1:0] pick_index;
  logic                  pick_valid;

  assign rel_normal  = (state_q == OWN) & ~hwait & (hlast[owner_q] | ~hreq[owner_q]);
  assign release_any = rel_normal | to_hit;
  assign owner_inc   = (owner_q == MASTER_BIT'(MASTER_NUM - 1)) ? '0 : owner_q + 1'b1;
  // On handover the releasing master goes to the back of the line.
  assign pick_start  = (state_q == OWN) ? owner_inc : rr_ptr_q;

  rr_pick #(
    .MASTER_NUM (MASTER_NUM),
    .MASTER_BIT (MASTER_BIT)
  ) u_pick (
    .req    (hreq),
    .start  (pick_start),
    .onehot (pick_onehot),
    .index  (pick_index),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWN;
          owner_d = pick_index;
          grant_d = pick_onehot;
        end
      end
      OWN: begin
        if (release_any) begin
          rr_ptr_d = owner_inc;
          if (pick_valid) begin
            owner_d = pick_index;
            grant_d = pick_onehot;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef AHB_ARB_TIMEOUT_EN
  logic [TO_BIT-1:0] wdog_q, wdog_d;

  // Counts consecutive stalled owner cycles; the stall that would reach the limit releases.
  assign to_hit = (state_q == OWN) & hwait & (wdog_q == TO_BIT'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d = '0;
    if ((state_q == OWN) && hwait && !release_any) wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge hclk) begin
    if (hreset) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end

  assign timeout_err = to_hit & ~rel_normal & ~hreset;
`else
  logic unused_cfg;
  assign unused_cfg  = ^TO_BIT'(TIMEOUT_CYCLES);
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign hgrant  = grant_q;
  assign hsel    = |grant_q;
  assign hmaster = owner_q;

endmodule
